// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU: ALUControl codes, FSM states
// and operand width. The code values are shared with the ALU control decoder.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_ADDI = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between the operand mux, the ALU and
// the writeback/branch consumer.
interface alu_exec_unit_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               alu_control;
    logic [alu_pkg::XLEN-1:0] operand_a;
    logic [alu_pkg::XLEN-1:0] operand_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [alu_pkg::XLEN-1:0] result;
    logic                     zero;

    modport master (
        output in_valid, alu_control, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_control, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface

// File: rtl/alu_shift_step.sv
// One step of the iterative shifter: shifts a value left, right-logical or
// right-arithmetic by 0..SHIFT_STEP bit positions.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic [XLEN-1:0] i_value,
    input  logic [4:0]      i_amount,
    input  logic            i_left,
    input  logic            i_arith,
    output logic [XLEN-1:0] o_value
);

    localparam logic [4:0] MAX_AMT = 5'(SHIFT_STEP);

    logic [4:0]             w_amt;
    logic signed [XLEN-1:0] w_sra;

    // Bound the step so the shifter never grows beyond SHIFT_STEP positions
    assign w_amt = (i_amount > MAX_AMT) ? MAX_AMT : i_amount;
    // Kept in its own signed net so the arithmetic shift is not demoted to logical
    assign w_sra = $signed(i_value) >>> w_amt;

    assign o_value = i_left  ? (i_value << w_amt) :
                     i_arith ? w_sra :
                               (i_value >> w_amt);

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/arith/compare ops and an iterative
// shifter, with valid/ready handshakes on request and result sides.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    alu_state_e      r_state;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_shift_val;
    logic [4:0]      r_remaining;
    logic            r_out_valid;
    logic            r_zero;
    logic            r_left;
    logic            r_arith;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_consume;
    logic [4:0]      w_shamt;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] w_alu_res;
    logic [4:0]      w_step;
    logic [4:0]      w_rem_next;
    logic [XLEN-1:0] w_shifted;

    assign w_in_ready = !reset && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = r_out_valid && bus.out_ready;
    assign w_shamt    = bus.operand_b[4:0];
    assign w_slt      = $signed(bus.operand_a) < $signed(bus.operand_b);
    assign w_sltu     = bus.operand_a < bus.operand_b;
    assign w_step     = (r_remaining > STEP) ? STEP : r_remaining;
    assign w_rem_next = r_remaining - w_step;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

    // Single-cycle result; shifts land here only when their amount is zero
    always_comb begin
        w_alu_res = {XLEN{1'b0}};
        case (bus.alu_control)
            ALU_AND:                   w_alu_res = bus.operand_a & bus.operand_b;
            ALU_OR:                    w_alu_res = bus.operand_a | bus.operand_b;
            ALU_ADD, ALU_ADDI:         w_alu_res = bus.operand_a + bus.operand_b;
            ALU_SUB:                   w_alu_res = bus.operand_a - bus.operand_b;
            ALU_XOR:                   w_alu_res = bus.operand_a ^ bus.operand_b;
            ALU_SLT:                   w_alu_res = {{(XLEN-1){1'b0}}, w_slt};
            ALU_SLTU:                  w_alu_res = {{(XLEN-1){1'b0}}, w_sltu};
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = bus.operand_a;
            default:                   w_alu_res = {XLEN{1'b0}};
        endcase
    end

    alu_shift_step #(
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .i_value  (r_shift_val),
        .i_amount (w_step),
        .i_left   (r_left),
        .i_arith  (r_arith),
        .o_value  (w_shifted)
    );

    // Control FSM plus shift datapath and registered result/zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_result    <= {XLEN{1'b0}};
            r_shift_val <= {XLEN{1'b0}};
            r_remaining <= 5'd0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_left      <= 1'b0;
            r_arith     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        if (is_shift_op(bus.alu_control) && (w_shamt != 5'd0)) begin
                            r_state     <= SHIFT;
                            r_shift_val <= bus.operand_a;
                            r_remaining <= w_shamt;
                            r_left      <= (bus.alu_control == ALU_SLL);
                            r_arith     <= (bus.alu_control == ALU_SRA);
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= DONE;
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == {XLEN{1'b0}});
                            r_out_valid <= 1'b1;
                        end
                    end else if (w_consume) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                SHIFT: begin
                    r_shift_val <= w_shifted;
                    r_remaining <= w_rem_next;
                    if (w_rem_next == 5'd0) begin
                        r_state     <= DONE;
                        r_result    <= w_shifted;
                        r_zero      <= (w_shifted == {XLEN{1'b0}});
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// ops checked against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int STEP = 1;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if bus ();

    alu_exec_unit #(.SHIFT_STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = b[4:0];
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (c)
            4'd0:        return a & b;
            4'd1:        return a | b;
            4'd2, 4'd10: return a + b;
            4'd3:        return a << sh;
            4'd4:        return a >> sh;
            4'd5:        return (a >> sh) | fill;
            4'd6:        return a - b;
            4'd7:        return a ^ b;
            4'd8:        return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:        return (a < b) ? 32'd1 : 32'd0;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        int k;
        k = int'(b[4:0]);
        if ((c == 4'd3 || c == 4'd4 || c == 4'd5) && k > 0) return (k + STEP - 1) / STEP;
        return 0;
    endfunction

    // Present one request, wait for acceptance, then count edges until out_valid.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit rdy_seen);
        int w;
        w = 0;
        bus.alu_control = c;
        bus.operand_a   = a;
        bus.operand_b   = b;
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.alu_control = 4'($urandom);
        bus.operand_a   = $urandom;
        bus.operand_b   = $urandom;
        lat = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_control = 4'd0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
        n_tests++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        reset = 1'b0;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready   = 1'b1;
        bus.alu_control = 4'd2;
        bus.operand_a   = 32'h7FFF_FFFF;
        bus.operand_b   = 32'd1;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000 || bus.zero !== 1'b0) begin
            n_fail++; $display("FAIL b2b_add: got v=%b r=%h z=%b want v=1 r=80000000 z=0", bus.out_valid, bus.result, bus.zero); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
        bus.alu_control = 4'd6;
        bus.operand_a   = 32'd5;
        bus.operand_b   = 32'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
            n_fail++; $display("FAIL b2b_sub: got v=%b r=%h z=%b want v=1 r=0 z=1", bus.out_valid, bus.result, bus.zero); end
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_shift_sra31();
        int lat; bit rdy;
        bus.out_ready = 1'b1;
        issue(4'd5, 32'h8000_0000, 32'd31, lat, rdy);
        n_tests++; if (lat !== 31) begin n_fail++; $display("FAIL sra31_latency: got %0d want 31", lat); end
        n_tests++; if (bus.result !== 32'hFFFF_FFFF || bus.zero !== 1'b0) begin
            n_fail++; $display("FAIL sra31_result: got %h z=%b want ffffffff z=0", bus.result, bus.zero); end
        n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL sra31_in_ready: got %b want 0 during shift", rdy); end
        consume();
    endtask

    task automatic test_compare_sll0();
        int lat; bit rdy;
        logic [31:0] a;
        bus.out_ready = 1'b1;
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, lat, rdy);
        n_tests++; if (bus.result !== 32'd1 || lat !== 0) begin n_fail++; $display("FAIL slt: got %h lat=%0d want 1 lat=0", bus.result, lat); end
        consume();
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, lat, rdy);
        n_tests++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL sltu: got %h z=%b want 0 z=1", bus.result, bus.zero); end
        consume();
        a = $urandom | 32'h1;
        issue(4'd3, a, 32'hFFFF_FFE0, lat, rdy);
        n_tests++; if (bus.result !== a || lat !== 0) begin n_fail++; $display("FAIL sll0: got %h lat=%0d want %h lat=0", bus.result, lat, a); end
        consume();
    endtask

    task automatic test_hold();
        int lat; bit rdy;
        bus.out_ready = 1'b0;
        issue(4'd7, 32'hF0F0_F0F0, 32'hFFFF_FFFF, lat, rdy);
        for (int i = 0; i < 5; i++) begin
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
            bus.alu_control = 4'($urandom);
            @(posedge clk); #1;
            n_tests++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h0F0F_0F0F || bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_cycle%0d: got v=%b r=%h rdy=%b want v=1 r=0f0f0f0f rdy=0", i, bus.out_valid, bus.result, bus.in_ready); end
        end
        consume();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_consume: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_midshift();
        int lat; bit rdy;
        bus.out_ready   = 1'b1;
        bus.alu_control = 4'd4;
        bus.operand_a   = 32'hFFFF_0000;
        bus.operand_b   = 32'd20;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midshift_busy: got v=%b rdy=%b want v=0 rdy=0", bus.out_valid, bus.in_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++; $display("FAIL midshift_reset: got v=%b r=%h want v=0 r=0", bus.out_valid, bus.result); end
        reset = 1'b0;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midshift_idle: got in_ready=%b want 1", bus.in_ready); end
        issue(4'd0, 32'h0000_00FF, 32'h0000_000F, lat, rdy);
        n_tests++; if (bus.result !== 32'h0000_000F || lat !== 0) begin
            n_fail++; $display("FAIL midshift_and: got %h lat=%0d want 0000000f lat=0", bus.result, lat); end
        consume();
        bus.out_ready = 1'b0;
        issue(4'd1, 32'd1, 32'd0, lat, rdy);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++; $display("FAIL held_reset: got v=%b r=%h want v=0 r=0", bus.out_valid, bus.result); end
    endtask

    task automatic test_invalid_code();
        int lat; bit rdy;
        bus.out_ready = 1'b1;
        for (int c = 11; c < 16; c++) begin
            issue(4'(c), $urandom | 32'h1, $urandom | 32'h1, lat, rdy);
            n_tests++; if (bus.result !== 32'd0 || bus.zero !== 1'b1 || lat !== 0) begin
                n_fail++; $display("FAIL invalid_code_%0d: got r=%h z=%b lat=%0d want r=0 z=1 lat=0", c, bus.result, bus.zero, lat); end
            consume();
        end
    endtask

    task automatic test_random();
        int lat; bit rdy;
        logic [3:0] c; logic [31:0] a, b, exp;
        int stall;
        for (int i = 0; i < 150; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            exp = ref_alu(c, a, b);
            bus.out_ready = 1'($urandom_range(0, 1));
            issue(c, a, b, lat, rdy);
            n_tests++; if (bus.result !== exp || bus.zero !== (exp == 32'd0)) begin
                n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h z=%b want %h z=%b", c, a, b, bus.result, bus.zero, exp, exp == 32'd0); end
            n_tests++; if (lat !== ref_lat(c, b)) begin
                n_fail++; $display("FAIL rand_latency op=%0d b=%h: got %0d want %0d", c, b, lat, ref_lat(c, b)); end
            if (!bus.out_ready) begin
                stall = $urandom_range(0, 3);
                repeat (stall) begin @(posedge clk); #1; end
                n_tests++; if (bus.out_valid !== 1'b1 || bus.result !== exp) begin
                    n_fail++; $display("FAIL rand_hold: got v=%b r=%h want v=1 r=%h", bus.out_valid, bus.result, exp); end
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift_sra31();
        test_compare_sll0();
        test_hold();
        test_reset_midshift();
        test_invalid_code();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
